// File: rtl/cdb_pkg.sv
// Shared widths and the CDB token type for the Common Data Bus arbiter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package cdb_pkg;

  localparam int CDB_NUM_REQ = 4;
  localparam int CDB_TAG_W   = 5;
  localparam int CDB_DATA_W  = 32;
  localparam int CDB_SRC_W   = 3;   // enough to name any of up to 8 requesters

  // One broadcast on the CDB; valid is part of the token so that an idle
  // bus never matches a valid RST entry, even when the held tag is 0.
  typedef struct packed {
    logic                  valid;
    logic [CDB_TAG_W-1:0]  tag;
    logic [CDB_DATA_W-1:0] data;
    logic [CDB_SRC_W-1:0]  src;
  } cdb_token_t;

endpackage

// File: rtl/cdb_arbiter_rr_pick.sv
// One-hot winner from a request vector, starting the search at ptr and wrapping.
// Latency: purely combinational.
// Backpressure: none; requesters that lose simply hold their request.
module rr_pick #(
  parameter int N     = 4,
  parameter int PTR_W = 2
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N-1:0]     gnt
);

  logic [N-1:0] masked;

  // Keep only the requests at or above the pointer.
  always_comb begin
    masked = '0;
    for (int i = 0; i < N; i++) begin
      masked[i] = req[i] && (i >= int'(ptr));
    end
  end

  // Lowest masked request wins; if none lie at or above the pointer, wrap
  // around and take the lowest request overall.
  always_comb begin
    gnt = '0;
    if (|masked) begin
      for (int i = N - 1; i >= 0; i--) begin
        if (masked[i]) begin
          gnt    = '0;
          gnt[i] = 1'b1;
        end
      end
    end else begin
      for (int i = N - 1; i >= 0; i--) begin
        if (req[i]) begin
          gnt    = '0;
          gnt[i] = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// CDB arbiter: grants one functional-unit completion per cycle and registers it as the CDB token (CDB_RR_EN selects round-robin, else fixed priority).
// Latency: grant is combinational; token appears on cdb_* one cycle after the grant.
// Backpressure: losing units hold fu_req/fu_tag/fu_data until granted; flush suppresses all grants for the cycle.
module cdb_arbiter
  import cdb_pkg::*;
#(
  parameter int NUM_REQ = CDB_NUM_REQ,
  parameter int TAG_W   = CDB_TAG_W,
  parameter int DATA_W  = CDB_DATA_W
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        fu_req,
  input  logic [NUM_REQ*TAG_W-1:0]  fu_tag,
  input  logic [NUM_REQ*DATA_W-1:0] fu_data,
  output logic [NUM_REQ-1:0]        fu_gnt,
  input  logic                      flush,
  output logic                      cdb_valid,
  output logic [TAG_W-1:0]          cdb_tag,
  output logic [DATA_W-1:0]         cdb_data,
  output logic [2:0]                cdb_src
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [PTR_W-1:0]     pick_ptr;
  logic [NUM_REQ-1:0]   raw_gnt;
  logic [CDB_SRC_W-1:0] win_idx;
  logic [TAG_W-1:0]     win_tag;
  logic [DATA_W-1:0]    win_data;
  cdb_token_t           tok_q;

  rr_pick #(
    .N     (NUM_REQ),
    .PTR_W (PTR_W)
  ) u_pick (
    .req (fu_req),
    .ptr (pick_ptr),
    .gnt (raw_gnt)
  );

  // A flush or a reset in progress must not hand any unit a grant.
  assign fu_gnt = (reset || flush) ? '0 : raw_gnt;

  // Encode the winner and steer its tag and result toward the token register.
  always_comb begin
    win_idx  = '0;
    win_tag  = '0;
    win_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (fu_gnt[i]) begin
        win_idx  = CDB_SRC_W'(i);
        win_tag  = fu_tag[i*TAG_W +: TAG_W];
        win_data = fu_data[i*DATA_W +: DATA_W];
      end
    end
  end

`ifdef CDB_RR_EN
  logic [PTR_W-1:0] rr_ptr;

  // Move the search start to just past the last winner; hold when idle or flushed.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rr_ptr <= '0;
    end else if (|fu_gnt) begin
      if (win_idx == CDB_SRC_W'(NUM_REQ - 1)) begin
        rr_ptr <= '0;
      end else begin
        rr_ptr <= PTR_W'(win_idx + CDB_SRC_W'(1));
      end
    end
  end

  assign pick_ptr = rr_ptr;
`else
  // Fixed priority: the search always starts at unit 0.
  assign pick_ptr = '0;
`endif

  // Token register: valid pulses once per grant; tag, data and source hold
  // their last broadcast values while the bus is idle.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      tok_q <= '0;
    end else begin
      tok_q.valid <= |fu_gnt;
      if (|fu_gnt) begin
        tok_q.tag  <= CDB_TAG_W'(win_tag);
        tok_q.data <= CDB_DATA_W'(win_data);
        tok_q.src  <= win_idx;
      end
    end
  end

  assign cdb_valid = tok_q.valid;
  assign cdb_tag   = TAG_W'(tok_q.tag);
  assign cdb_data  = DATA_W'(tok_q.data);
  assign cdb_src   = tok_q.src;

endmodule
